// File: rtl/mem_arbiter.sv
// Two-port cache-to-memory arbiter: round-robin one-hot grant, one transfer in
// flight, watchdog abort with a sticky error flag.
module mem_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 128,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_rw,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] req_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              tmo_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nx;
    logic [1:0]        grant_q, grant_nx;
    logic              prio, prio_nx;
    logic [TMO_W-1:0]  wdog, wdog_nx, wdog_inc;
    logic              tmo_q, tmo_nx;
    logic              gsel;

    assign gsel = grant_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            prio    <= 1'b0;
            wdog    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            prio    <= prio_nx;
            wdog    <= wdog_nx;
            tmo_q   <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        prio_nx  = prio;
        wdog_nx  = wdog;
        tmo_nx   = tmo_q;
        wdog_inc = wdog + 1'b1;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nx = BUSY;
                    wdog_nx  = '0;
                    if (req_valid[1] && (!req_valid[0] || prio))
                        grant_nx = 2'b10;
                    else
                        grant_nx = 2'b01;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    prio_nx  = ~gsel;
                end else begin
                    wdog_nx = wdog_inc;
                    // abort on the cycle the counter would reach all-ones
                    if (wdog_inc == '1) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        prio_nx  = ~prio;
                        tmo_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_ready = 2'b00;
        req_rdata = '0;
        if (state == BUSY) begin
            mem_valid = 1'b1;
            mem_rw    = req_rw[gsel];
            mem_addr  = gsel ? req_addr1 : req_addr0;
            mem_wdata = gsel ? req_data1 : req_data0;
            req_ready = grant_q & {2{mem_ready}};
            req_rdata = mem_rdata;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state == BUSY);
    assign tmo_err = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a transaction-level owner/age model.
module tb_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 128;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_rw, req_ready, grant;
    logic [AW-1:0] req_addr0, req_addr1, mem_addr;
    logic [DW-1:0] req_data0, req_data1, req_rdata, mem_wdata, mem_rdata;
    logic          mem_valid, mem_rw, mem_ready, busy, tmo_err;

    int total = 0;
    int bad   = 0;

    // model: owner = -1 when nobody holds memory, age = BUSY cycles without ready
    int m_owner, m_prio, m_age;
    bit m_err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy), .tmo_err(tmo_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [1:0]    eg, er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, erd;
        logic          erw;
        eg = 2'b00; er = 2'b00; ea = '0; ew = '0; erd = '0; erw = 1'b0;
        if (m_owner >= 0) begin
            eg  = (m_owner == 0) ? 2'b01 : 2'b10;
            ea  = (m_owner == 0) ? req_addr0 : req_addr1;
            ew  = (m_owner == 0) ? req_data0 : req_data1;
            erw = req_rw[m_owner];
            erd = mem_rdata;
            if (mem_ready) er = eg;
        end
        chk("grant", grant, eg);
        chk("busy", busy, m_owner >= 0);
        chk("mem_valid", mem_valid, m_owner >= 0);
        chk("mem_rw", mem_rw, erw);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("req_ready", req_ready, er);
        chk("req_rdata", req_rdata, erd);
        chk("tmo_err", tmo_err, m_err);
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            if (req_valid != 2'b00) begin
                m_owner = (req_valid == 2'b11) ? m_prio : (req_valid[1] ? 1 : 0);
                m_age   = 0;
            end
        end else if (mem_ready) begin
            m_prio  = 1 - m_owner;
            m_owner = -1;
        end else begin
            m_age++;
            if (m_age == (1 << TW) - 1) begin
                m_err   = 1'b1;
                m_prio  = 1 - m_prio;
                m_owner = -1;
            end
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] rw, input logic mr,
                         input logic [DW-1:0] mrd);
        req_valid = v;
        req_rw    = rw;
        mem_ready = mr;
        mem_rdata = mrd;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_owner = -1; m_prio = 0; m_age = 0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        req_valid = 2'b11; req_rw = 2'b00; mem_ready = 1'b1; mem_rdata = '1;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
        do_reset();

        // single read on port 0, ready on the 3rd BUSY cycle
        req_addr0 = 20'h00AB0;
        drive(2'b01, 2'b00, 1'b0, '0);
        tick();
        chk("r037_grant", grant, 2'b01);
        drive(2'b01, 2'b00, 1'b0, '0); tick();
        drive(2'b01, 2'b00, 1'b0, '0); tick();
        drive(2'b00, 2'b00, 1'b1, 128'h1234);
        chk("r037_addr", mem_addr, 20'h00AB0);
        chk("r037_ready", req_ready, 2'b01);
        chk("r037_rdata", req_rdata, 128'h1234);
        tick();
        chk("r037_idle", busy, 1'b0);

        // simultaneous requests: port 0 first, port 1 after a bubble
        do_reset();
        drive(2'b11, 2'b00, 1'b0, '0); tick();
        chk("r038_first", grant, 2'b01);
        drive(2'b11, 2'b00, 1'b1, 128'h55); tick();
        drive(2'b11, 2'b00, 1'b0, '0);
        chk("r038_bubble", grant, 2'b00);
        tick();
        chk("r038_second", grant, 2'b10);
        drive(2'b11, 2'b00, 1'b1, 128'h66); tick();
        drive(2'b11, 2'b00, 1'b0, '0); tick();
        chk("r038_prio0", grant, 2'b01);

        // fairness: six back-to-back transfers alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'b00, 1'b0, '0); tick();
            chk("r040_seq", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            drive(2'b11, 2'b00, 1'b1, 128'(i)); tick();
        end

        // write-back then allocate on port 1
        do_reset();
        req_addr1 = 20'h3C0F0; req_data1 = 128'hDEAD_BEEF_0000_1111;
        drive(2'b10, 2'b10, 1'b0, '0); tick();
        drive(2'b10, 2'b10, 1'b1, '0);
        chk("r039_wr", mem_rw, 1'b1);
        chk("r039_wdata", mem_wdata, 128'hDEAD_BEEF_0000_1111);
        tick();
        drive(2'b10, 2'b00, 1'b0, '0);
        chk("r039_bubble", busy, 1'b0);
        tick();
        chk("r039_regrant", grant, 2'b10);
        drive(2'b10, 2'b00, 1'b1, 128'h77);
        chk("r039_rd", mem_rw, 1'b0);
        tick();

        // reset mid-transfer
        do_reset();
        drive(2'b11, 2'b00, 1'b0, '0); tick();
        drive(2'b11, 2'b00, 1'b0, '0); tick();
        drive(2'b11, 2'b00, 1'b0, '0);
        mem_ready = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("r042_valid", mem_valid, 1'b0);
        chk("r042_grant", grant, 2'b00);
        chk("r042_ready", req_ready, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2'b11, 2'b00, 1'b0, '0); tick();
        chk("r042_after", grant, 2'b01);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_addr0 = AW'($urandom); req_addr1 = AW'($urandom);
            req_data0 = rnd_wide();    req_data1 = rnd_wide();
            drive(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), rnd_wide());
            tick();
        end

        // watchdog: no mem_ready, abort after seven BUSY cycles
        do_reset();
        drive(2'b01, 2'b00, 1'b0, '0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, 2'b00, 1'b0, '0);
            chk("r041_noready", req_ready, 2'b00);
            tick();
        end
        chk("r041_err", tmo_err, 1'b1);
        chk("r041_idle", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 2'b00, 1'b1, '0); tick();
        end
        chk("r041_sticky", tmo_err, 1'b1);
        do_reset();
        chk("r041_clear", tmo_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
